mcu51_alu_seq: RTL

// - Parametrised, handshaked MCU51 execute-stage ALU. Adds iterative MUL AB / DIV AB to the full 8051 op set.
// - Sits between the decoder (issues ALUCode + operands) and PSW/ACC/B writeback.
// - Single-cycle ops retire one cycle after issue. MUL/DIV retire after WIDTH iterations.

---
 rtl/mcu51_alu_pkg.sv | 40 ++++
 rtl/mcu51_alu_seq_if.sv | 30 +++
 rtl/mcu51_muldiv_iter.sv | 91 +++++++++
 rtl/mcu51_alu_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu51_alu_pkg.sv
// Shared definitions for the MCU51 execute-stage ALU: opcodes, FSM states, flag payload.
package mcu51_alu_pkg;

    localparam logic [3:0] ALU_INC  = 4'b0000;
    localparam logic [3:0] ALU_DEC  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDC = 4'b0011;
    localparam logic [3:0] ALU_ORL  = 4'b0100;
    localparam logic [3:0] ALU_ANL  = 4'b0101;
    localparam logic [3:0] ALU_XRL  = 4'b0110;
    localparam logic [3:0] ALU_CPL  = 4'b0111;
    localparam logic [3:0] ALU_DA   = 4'b1000;
    localparam logic [3:0] ALU_SUBB = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_RR   = 4'b1100;
    localparam logic [3:0] ALU_RRC  = 4'b1101;
    localparam logic [3:0] ALU_RL   = 4'b1110;
    localparam logic [3:0] ALU_RLC  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // PSW flag writeback payload
    typedef struct packed {
        logic cy;
        logic ac;
        logic ov;
    } alu_flags_t;

    // Operand width must be whole nibbles (DA works per nibble) and at least a byte
    function automatic bit width_ok(input int unsigned w);
        return (w >= 8) && ((w % 4) == 0);
    endfunction

endpackage

// File: rtl/mcu51_alu_seq_if.sv
// Decoder <-> ALU issue/writeback bus.
interface mcu51_alu_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CODE_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] ALUCode;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              Cy;
    logic              AC;
    logic              flush;
    logic              out_valid;
    logic [WIDTH-1:0]  Result;
    logic [WIDTH-1:0]  ResultB;
    logic              Carry;
    logic              AssistantCarry;
    logic              OVerflow;

    modport master (
        output in_valid, ALUCode, A, B, Cy, AC, flush,
        input  in_ready, out_valid, Result, ResultB, Carry, AssistantCarry, OVerflow
    );

    modport slave (
        input  in_valid, ALUCode, A, B, Cy, AC, flush,
        output in_ready, out_valid, Result, ResultB, Carry, AssistantCarry, OVerflow
    );
endinterface

// File: rtl/mcu51_muldiv_iter.sv
// Iterative one-bit-per-cycle MUL (shift-add) / DIV (restoring) datapath.
// The last step is presented combinationally on *_c_o so the caller can retire in the same edge.
module mcu51_muldiv_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_c_o,
    output logic [WIDTH-1:0] lo_c_o,
    output logic [WIDTH-1:0] hi_c_o,
    output logic             ov_c_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             busy_q;
    logic             div_q;
    logic             dz_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   psum;
    logic             qbit;
    logic             done_c;

    // One iteration: hi:lo is the partial product / remainder:quotient pair
    always_comb begin
        trial = {hi_q, lo_q[WIDTH-1]};
        psum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        qbit  = 1'b0;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (div_q) begin
            if (trial >= {1'b0, b_q}) begin
                qbit  = 1'b1;
                trial = trial - {1'b0, b_q};
            end
            hi_d = trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], qbit};
        end else begin
            {hi_d, lo_d} = {psum, lo_q[WIDTH-1:1]};
        end
    end

    // Divide-by-zero finishes on the first busy cycle with the architectural fill values
    assign done_c   = busy_q && (dz_q || (cnt_q == CNT_W'(WIDTH - 1)));
    assign done_c_o = done_c;
    assign busy_o   = busy_q;
    assign lo_c_o   = dz_q ? '1 : lo_d;
    assign hi_c_o   = dz_q ? lo_q : hi_d;
    assign ov_c_o   = dz_q | (!div_q && (hi_d != '0));

    // Operand load on start, then step until done or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= div_i;
            dz_q   <= div_i && (b_i == '0);
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= a_i;
            b_q    <= b_i;
        end else if (busy_q) begin
            if (abort_i || done_c) begin
                busy_q <= 1'b0;
            end else begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mcu51_alu_seq.sv
// MCU51 execute-stage ALU with handshake, single-cycle ops and iterative MUL AB / DIV AB.
module mcu51_alu_seq
    import mcu51_alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CODE_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mcu51_alu_seq_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;

    if (!width_ok(WIDTH)) begin : g_width_chk
        $error("mcu51_alu_seq: WIDTH must be a multiple of 4 and >= 8");
    end

    alu_state_e       state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] resb_q;
    alu_flags_t       flags_q;
    logic             ac_q;

    logic [WIDTH-1:0] res_d;
    alu_flags_t       flg_d;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [4:0]       add_n;
    logic [4:0]       sub_n;
    logic             add_ov;
    logic             sub_ov;
    logic [WIDTH-1:0] da_v;
    logic             da_c;
    logic             da_adj;
    logic [4:0]       nib5;
    logic [4:0]       nib6;
    logic             is_mul;
    logic             is_div;
    logic             accept;
    logic             md_busy;
    logic             md_done_c;
    logic [WIDTH-1:0] md_lo_c;
    logic [WIDTH-1:0] md_hi_c;
    logic             md_ov_c;

    assign is_mul = (bus.ALUCode == CODE_W'(ALU_MUL));
    assign is_div = (bus.ALUCode == CODE_W'(ALU_DIV));
    assign accept = (state_q == ST_IDLE) && bus.in_valid && !bus.flush;

    // Shared adder/subtractor; inc/dec use a constant 1 operand
    always_comb begin
        opb = bus.B;
        cin = 1'b0;
        if ((bus.ALUCode == CODE_W'(ALU_INC)) || (bus.ALUCode == CODE_W'(ALU_DEC))) begin
            opb = WIDTH'(1);
        end
        if ((bus.ALUCode == CODE_W'(ALU_ADDC)) || (bus.ALUCode == CODE_W'(ALU_SUBB))) begin
            cin = bus.Cy;
        end
        add_w  = {1'b0, bus.A} + {1'b0, opb} + (WIDTH+1)'(cin);
        sub_w  = {1'b0, bus.A} - {1'b0, opb} - (WIDTH+1)'(cin);
        add_n  = {1'b0, bus.A[3:0]} + {1'b0, opb[3:0]} + 5'(cin);
        sub_n  = {1'b0, bus.A[3:0]} - {1'b0, opb[3:0]} - 5'(cin);
        add_ov = (bus.A[WIDTH-1] == opb[WIDTH-1]) && (add_w[WIDTH-1] != bus.A[WIDTH-1]);
        sub_ov = (bus.A[WIDTH-1] != opb[WIDTH-1]) && (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
    end

    // Decimal adjust: +6 per nibble, carries ripple upward; overflow of a nibble forces its adjust
    always_comb begin
        da_v   = bus.A;
        da_c   = 1'b0;
        da_adj = 1'b0;
        nib5   = '0;
        nib6   = '0;
        for (int i = 0; i < int'(NIB); i++) begin
            nib5   = {1'b0, da_v[4*i +: 4]} + 5'(da_c);
            da_adj = (nib5[3:0] > 4'd9) || nib5[4]
                     || ((i == 0) && bus.AC) || ((i == int'(NIB) - 1) && bus.Cy);
            nib6   = {1'b0, nib5[3:0]} + 5'd6;
            if (da_adj) begin
                da_v[4*i +: 4] = nib6[3:0];
                da_c           = nib5[4] | nib6[4];
            end else begin
                da_v[4*i +: 4] = nib5[3:0];
                da_c           = nib5[4];
            end
        end
    end

    // Single-cycle result and flag select
    always_comb begin
        res_d = '0;
        flg_d = '{cy: bus.Cy, ac: bus.AC, ov: 1'b0};
        case (bus.ALUCode)
            CODE_W'(ALU_INC), CODE_W'(ALU_ADD), CODE_W'(ALU_ADDC): begin
                res_d = add_w[WIDTH-1:0];
                flg_d = '{cy: add_w[WIDTH], ac: add_n[4], ov: add_ov};
            end
            CODE_W'(ALU_DEC), CODE_W'(ALU_SUBB): begin
                res_d = sub_w[WIDTH-1:0];
                flg_d = '{cy: sub_w[WIDTH], ac: sub_n[4], ov: sub_ov};
            end
            CODE_W'(ALU_ORL): res_d = bus.A | bus.B;
            CODE_W'(ALU_ANL): res_d = bus.A & bus.B;
            CODE_W'(ALU_XRL): res_d = bus.A ^ bus.B;
            CODE_W'(ALU_CPL): res_d = ~bus.A;
            CODE_W'(ALU_DA): begin
                res_d = da_v;
                flg_d = '{cy: bus.Cy | da_c, ac: 1'b0, ov: 1'b0};
            end
            CODE_W'(ALU_RR):  res_d = {bus.A[0], bus.A[WIDTH-1:1]};
            CODE_W'(ALU_RRC): begin
                res_d    = {bus.Cy, bus.A[WIDTH-1:1]};
                flg_d.cy = bus.A[0];
            end
            CODE_W'(ALU_RL):  res_d = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            CODE_W'(ALU_RLC): begin
                res_d    = {bus.A[WIDTH-2:0], bus.Cy};
                flg_d.cy = bus.A[WIDTH-1];
            end
            default: res_d = '0;
        endcase
    end

    mcu51_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && (is_mul || is_div)),
        .div_i    (is_div),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .abort_i  (bus.flush),
        .busy_o   (md_busy),
        .done_c_o (md_done_c),
        .lo_c_o   (md_lo_c),
        .hi_c_o   (md_hi_c),
        .ov_c_o   (md_ov_c)
    );

    // Control FSM with registered handshake and writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            resb_q      <= '0;
            flags_q     <= '0;
            ac_q        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ac_q       <= bus.AC;
                        in_ready_q <= 1'b0;
                        if (is_mul) begin
                            state_q <= ST_MUL;
                        end else if (is_div) begin
                            state_q <= ST_DIV;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= res_d;
                            resb_q      <= '0;
                            flags_q     <= flg_d;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (bus.flush) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end else if (md_busy && md_done_c) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_lo_c;
                        resb_q      <= md_hi_c;
                        flags_q     <= '{cy: 1'b0, ac: ac_q, ov: md_ov_c};
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.Result         = result_q;
    assign bus.ResultB        = resb_q;
    assign bus.Carry          = flags_q.cy;
    assign bus.AssistantCarry = flags_q.ac;
    assign bus.OVerflow       = flags_q.ov;

endmodule
